// File: rtl/sample_decim_pkg.sv
// sample_decim_pkg: shared constants and helpers for the sample decimator.
//   - Sample field layout (ch A, ch B, digital) and overall sample width.
//   - Reduction mode encodings.
//   - Window exponent limits, counter and accumulator widths.
//   - Helpers: config clamp and last-sample index of a window.
package sample_decim_pkg;

  localparam int AW        = 8;              // analog channel width
  localparam int NUM_CH    = 2;              // analog channels per sample
  localparam int DIG_W     = 2;              // digital pin bits
  localparam int DW        = NUM_CH*AW + DIG_W;
  localparam int MAX_SHIFT = 12;             // ratio 4096
  localparam int SW        = 4;              // Shift port width
  localparam int CNT_W     = MAX_SHIFT;      // counts 0 .. 2^MAX_SHIFT-1
  localparam int ACC_W     = AW + MAX_SHIFT; // sum of 4096 x 8'hFF fits

  // Field slices: CH_A=[7:0], CH_B=[15:8], DIG=[17:16]
  localparam int CH_A_LO = 0;
  localparam int CH_B_LO = AW;
  localparam int DIG_LO  = NUM_CH*AW;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_DECIM = 2'b01,
    MODE_AVG   = 2'b10,
    MODE_PEAK  = 2'b11
  } mode_e;

  // Effective exponent for a window. Pass mode is a window of one sample,
  // which makes it share the Shift=0 path.
  function automatic logic [SW-1:0] clamp_shift(input mode_e m, input logic [SW-1:0] s);
    if (m == MODE_PASS)          return '0;
    if (s > SW'(MAX_SHIFT))      return SW'(MAX_SHIFT);
    return s;
  endfunction

  // Index of the last sample in a window of 2^s samples (s <= MAX_SHIFT).
  function automatic logic [CNT_W-1:0] win_last(input logic [SW-1:0] s);
    logic [CNT_W:0] one;
    logic [CNT_W:0] t;
    one = {{CNT_W{1'b0}}, 1'b1};
    t   = (one << s) - one;
    return t[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sample_decim_if.sv
// sample_decim_if: sample stream in/out of the decimator.
//   master: source side (drives Din/DinValid/Mode/Shift, observes outputs)
//   slave : decimator side
interface sample_decim_if;
  import sample_decim_pkg::*;

  logic [DW-1:0] Din;
  logic          DinValid;
  logic [1:0]    Mode;
  logic [SW-1:0] Shift;
  logic [DW-1:0] Dout;
  logic          DoutValid;
  logic          PeakPh;
  logic          WinBusy;

  modport master (
    output Din, DinValid, Mode, Shift,
    input  Dout, DoutValid, PeakPh, WinBusy
  );

  modport slave (
    input  Din, DinValid, Mode, Shift,
    output Dout, DoutValid, PeakPh, WinBusy
  );
endinterface

// File: rtl/sample_decim_chan_reduce.sv
// chan_reduce: per-channel window reduction for one analog channel.
//   clk, rst : clock, synchronous active-high reset
//   din      : channel sample
//   vld      : din is a valid sample this cycle
//   first    : this sample opens a new window (restarts all state)
//   acc_nxt  : window sum including din
//   max_nxt  : window maximum including din
//   min_nxt  : window minimum including din
// The *_nxt outputs already include the current sample so the parent can
// emit the window result in the same cycle the last sample arrives.
module chan_reduce
  import sample_decim_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    din,
  input  logic             vld,
  input  logic             first,
  output logic [ACC_W-1:0] acc_nxt,
  output logic [AW-1:0]    max_nxt,
  output logic [AW-1:0]    min_nxt
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [AW-1:0]    max_q, max_d;
  logic [AW-1:0]    min_q, min_d;

  always_comb begin
    if (first) begin
      acc_nxt = ACC_W'(din);
      max_nxt = din;
      min_nxt = din;
    end else begin
      acc_nxt = acc_q + ACC_W'(din);
      max_nxt = (din > max_q) ? din : max_q;
      min_nxt = (din < min_q) ? din : min_q;
    end
    acc_d = vld ? acc_nxt : acc_q;
    max_d = vld ? max_nxt : max_q;
    min_d = vld ? min_nxt : min_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      max_q <= '0;
      min_q <= '0;
    end else begin
      acc_q <= acc_d;
      max_q <= max_d;
      min_q <= min_d;
    end
  end

endmodule

// File: rtl/sample_decim.sv
// sample_decim: power-of-two sample stream reducer ahead of the FIFO.
//   Mclk    : sample clock, rising edge
//   Reset   : synchronous active-high reset
//   bus     : slave side of sample_decim_if
//     Din/DinValid  raw 18-bit sample in ([7:0] A, [15:8] B, [17:16] dig)
//     Mode/Shift    reduction mode and window exponent (latched per window)
//     Dout/DoutValid reduced sample and its one-cycle write strobe
//     PeakPh        1 = max sample, 0 = min sample (peak mode only)
//     WinBusy       a window is partially accumulated
module sample_decim
  import sample_decim_pkg::*;
(
  input  logic           Mclk,
  input  logic           Reset,
  sample_decim_if.slave  bus
);

  // Window counter and latched config
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic [SW-1:0]    shift_q, shift_d;

  // First-sample capture and digital OR across the window
  logic [DW-1:0]    first_smp_q, first_smp_d;
  logic [DIG_W-1:0] dig_or_q, dig_or_d;

  // Output registers; min_pend_q holds the queued min strobe of a peak window
  logic [DW-1:0]    dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             ph_q, ph_d;
  logic             min_pend_q, min_pend_d;
  logic [DW-1:0]    min_data_q, min_data_d;

  // Current-window view: on the opening sample the live config applies
  logic             first;
  mode_e            cur_mode;
  logic [SW-1:0]    cur_shift;
  logic             last;
  logic [DW-1:0]    cur_first;
  logic [DIG_W-1:0] cur_dig_or;

  logic [NUM_CH-1:0][AW-1:0]    ch_din, ch_max, ch_min, ch_avg;
  logic [NUM_CH-1:0][ACC_W-1:0] ch_acc;

  always_comb begin
    first      = (cnt_q == '0);
    cur_mode   = first ? mode_e'(bus.Mode) : mode_q;
    cur_shift  = first ? clamp_shift(mode_e'(bus.Mode), bus.Shift) : shift_q;
    last       = bus.DinValid && (cnt_q == win_last(cur_shift));
    cur_first  = first ? bus.Din : first_smp_q;
    cur_dig_or = first ? bus.Din[DIG_LO +: DIG_W]
                       : (dig_or_q | bus.Din[DIG_LO +: DIG_W]);
  end

  assign ch_din[0] = bus.Din[CH_A_LO +: AW];
  assign ch_din[1] = bus.Din[CH_B_LO +: AW];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    chan_reduce u_red (
      .clk     (Mclk),
      .rst     (Reset),
      .din     (ch_din[g]),
      .vld     (bus.DinValid),
      .first   (first),
      .acc_nxt (ch_acc[g]),
      .max_nxt (ch_max[g]),
      .min_nxt (ch_min[g])
    );
    // Sum of 2^s samples >> s is at most 8'hFF, so truncation is lossless.
    assign ch_avg[g] = AW'(ch_acc[g] >> cur_shift);
  end

  // Counter, config latch, window capture
  always_comb begin
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    first_smp_d = first_smp_q;
    dig_or_d    = dig_or_q;
    if (bus.DinValid) begin
      cnt_d       = last ? '0 : cnt_q + CNT_W'(1);
      first_smp_d = cur_first;
      dig_or_d    = cur_dig_or;
      if (first) begin
        mode_d  = cur_mode;
        shift_d = cur_shift;
      end
    end
  end

  // Output mux. A queued min strobe always owns its cycle; a peak window is
  // at least two samples so a following peak/avg/decim window cannot close
  // in that cycle.
  always_comb begin
    dout_d     = dout_q;
    dv_d       = 1'b0;
    ph_d       = 1'b0;
    min_pend_d = 1'b0;
    min_data_d = min_data_q;
    if (min_pend_q) begin
      dout_d = min_data_q;
      dv_d   = 1'b1;
    end else if (last) begin
      dv_d = 1'b1;
      if (cur_shift == '0) begin
        dout_d = bus.Din;
      end else begin
        unique case (cur_mode)
          MODE_AVG:  dout_d = {cur_first[DIG_LO +: DIG_W], ch_avg[1], ch_avg[0]};
          MODE_PEAK: begin
            dout_d     = {cur_dig_or, ch_max[1], ch_max[0]};
            ph_d       = 1'b1;
            min_pend_d = 1'b1;
            min_data_d = {cur_dig_or, ch_min[1], ch_min[0]};
          end
          default:   dout_d = cur_first;  // decimate
        endcase
      end
    end
  end

  always_ff @(posedge Mclk) begin
    if (Reset) begin
      cnt_q       <= '0;
      mode_q      <= MODE_PASS;
      shift_q     <= '0;
      first_smp_q <= '0;
      dig_or_q    <= '0;
      dout_q      <= '0;
      dv_q        <= 1'b0;
      ph_q        <= 1'b0;
      min_pend_q  <= 1'b0;
      min_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      first_smp_q <= first_smp_d;
      dig_or_q    <= dig_or_d;
      dout_q      <= dout_d;
      dv_q        <= dv_d;
      ph_q        <= ph_d;
      min_pend_q  <= min_pend_d;
      min_data_q  <= min_data_d;
    end
  end

  assign bus.Dout      = dout_q;
  assign bus.DoutValid = dv_q;
  assign bus.PeakPh    = ph_q;
  assign bus.WinBusy   = (cnt_q != '0);

endmodule

// File: doc/sample_decim.md
Name: sample_decim

Overview:
- Acquisition front-end stage between the ADC/digital input pins and the FIFO write port.
- Reduces the per-clock 18-bit sample stream (two 8-bit analog channels plus two digital bits) by a programmable power-of-two factor.
- Reduction modes: plain decimation, boxcar average, or peak-detect (max/min pair).
- Outputs a qualified sample stream with a write strobe that the FIFO address control consumes in place of a free-running write clock enable.

Parameters:
- AW, 8, width of each analog channel field.
- MAX_SHIFT, 12, largest permitted decimation exponent (ratio 4096).

Ports:
- Mclk  input  1  main sample clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Din  input  18  raw sample: [7:0] ch A, [15:8] ch B, [17:16] digital.
- DinValid  input  1  Din carries a new sample this cycle.
- Mode  input  2  00 pass, 01 decimate, 10 average, 11 peak.
- Shift  input  4  ratio = 2^Shift; values above MAX_SHIFT clamp to MAX_SHIFT.
- Dout  output  18  reduced sample, same field layout as Din.
- DoutValid  output  1  one-cycle strobe, Dout valid.
- PeakPh  output  1  in peak mode: 1 = max sample, 0 = min sample; 0 in all other modes.
- WinBusy  output  1  a window is partially accumulated.

Behaviour:
- Reset: Dout=0, DoutValid=0, PeakPh=0, WinBusy=0; sample counter, accumulators and latched config cleared.
- Reset wins over DinValid in the same cycle; a partial window is discarded with no output.
- Config latch:
  - Mode and Shift are latched at the first valid sample of each window.
  - Changes mid-window take effect on the next window.
  - After Reset, the first DinValid latches the config.
- Window: 2^Shift valid samples; the counter advances only on DinValid. Gaps in DinValid stretch the window and never close it early.
- Latency: DoutValid asserts exactly 1 Mclk after the DinValid cycle carrying the window's last sample.
- Pass (00), or any mode with Shift=0: Dout = registered Din, DoutValid = registered DinValid.
- Decimate (01): output is the first sample of the window, all 18 bits.
- Average (10):
  - Per-channel accumulator of width AW+MAX_SHIFT (20 bits), unsigned.
  - Output = sum >> Shift, truncating, never exceeding 8'hFF.
  - Digital bits are taken from the first sample of the window.
- Peak (11), Shift>=1:
  - Per-channel running max and min, initialised from the window's first sample.
  - Outputs two strobes: max with PeakPh=1 at last+1, then min with PeakPh=0 at last+2.
  - Digital bits in both outputs = OR of all window samples (glitch capture).
  - Because the window is >=2 samples, the min strobe never collides with the next window's max strobe.
  - The next window's accumulation proceeds during the min cycle.
- WinBusy is 1 from the first sample of a window until the cycle its last sample is taken.
- Back-to-back windows with continuous DinValid produce no dropped samples.
- Counter wrap: at count = 2^Shift-1 the counter returns to 0 on the same valid cycle.

Decomposition:
- Shared package holds:
  - Mode encodings MODE_PASS/DECIM/AVG/PEAK.
  - Field slices CH_A=[7:0], CH_B=[15:8], DIG=[17:16].
  - MAX_SHIFT and the accumulator width.
- One natural sub-module, chan_reduce. It is instantiated twice, once per analog channel, and holds the accumulator plus the max and min registers for one 8-bit channel.
- The counter, config latch and output mux stay in sample_decim.

Test Plan:
- Pass mode, Shift=3, DinValid continuous, Din ramp 0..9 -> Dout identical to Din, delayed 1 cycle, DoutValid every cycle.
- Average, Shift=2, ch A samples 10,11,12,14 -> one strobe 1 cycle after the 4th sample, ch A=11 (47>>2).
- Peak, Shift=2, ch B 0x40,0x90,0x10,0x50, digital 00,01,00,10 -> max strobe 0x90/dig 11/PeakPh=1, then min strobe 0x10/dig 11/PeakPh=0 on the next cycle.
- Decimate, Shift=1, DinValid toggling 1,0,1,0 with samples A,B -> single strobe carrying A, one cycle after B is accepted; WinBusy high across the gap.
- Average, Shift=12, all samples 0xFF -> output 0xFF with no overflow; Shift=15 behaves identically to 12.
- Reset asserted after 3 of 4 samples -> no strobe; the next 4 samples produce a clean window result; Mode changed mid-window applies only to the following window.
